instruction_prefetch_queue: RTL

Fetch stage upstream of the single-cycle MIPS datapath. Issues word-aligned reads to a variable-latency instruction memory and buffers the returned words with their PCs in a small FIFO. Presents them to the datapath through a valid/ready handshake. Flushes and refetches on a branch/jump/JR redirect, discarding any stale in-flight response.

---
 rtl/instruction_prefetch_queue.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/instruction_prefetch_queue.sv
// instruction_prefetch_queue
//
// Fetch stage that feeds the single-cycle MIPS datapath. It issues word-aligned
// reads to a variable-latency instruction memory, with at most one request
// outstanding, and buffers each returned word with its PC in a DEPTH-entry FIFO.
// A redirect flushes the FIFO and restarts fetch. A response that was in flight
// at the time of the redirect is dropped when it arrives.
//
// Optional feature: define PREFETCH_BYPASS_EN to present a response
// combinationally in the cycle it arrives whenever the FIFO is empty.
//
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   redirect, redirect_pc      flush and restart fetch at redirect_pc (word-aligned)
//   imem_req, imem_addr        read request / word address to instruction memory
//   imem_ready                 memory accepts the request this cycle
//   imem_rvalid, imem_rdata    one-cycle response pulse and its data
//   instr_valid, instr,        head entry valid, its word and PC (both 0 when
//   instr_pc                   no entry is valid)
//   instr_ready                datapath consumes the head entry

module instruction_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_q;
    logic [31:0]   req_pc_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic          inflight_q;
    logic          discard_q;
    logic [63:0]   mem_q [DEPTH];

    logic        rsp;
    logic        rsp_keep;
    logic        fifo_empty;
    logic        bypass;
    logic        push;
    logic        pop;
    logic        accept;
    logic [CW:0] occupancy;
    logic [63:0] head;

    always_comb begin
        rsp        = imem_rvalid && inflight_q;
        // A response is kept only if it is not stale and no redirect flushes it now.
        rsp_keep   = rsp && !discard_q && !redirect;
        fifo_empty = (count_q == '0);
`ifdef PREFETCH_BYPASS_EN
        bypass     = fifo_empty && rsp_keep;
`else
        bypass     = 1'b0;
`endif
        head        = mem_q[rd_ptr_q];
        instr_valid = !fifo_empty || bypass;
        instr       = 32'h0;
        instr_pc    = 32'h0;
        if (!fifo_empty) begin
            instr    = head[63:32];
            instr_pc = head[31:0];
        end else if (bypass) begin
            instr    = imem_rdata;
            instr_pc = req_pc_q;
        end

        pop  = !fifo_empty && instr_ready && !redirect;
        // A bypassed word consumed this cycle never occupies a FIFO slot.
        push = rsp_keep && !(bypass && instr_ready);

        // Counting the push that lands this cycle reserves room for the next response.
        occupancy = {1'b0, count_q} + {{CW{1'b0}}, push};
        imem_req  = !reset && !redirect && !(inflight_q && !imem_rvalid)
                    && (occupancy < (CW + 1)'(DEPTH));
        imem_addr = fetch_pc_q;
        accept    = imem_req && imem_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= 32'h0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            if (accept) begin
                inflight_q <= 1'b1;
                fetch_pc_q <= fetch_pc_q + 32'd4;
                req_pc_q   <= fetch_pc_q;
            end else if (rsp) begin
                inflight_q <= 1'b0;
            end

            if (redirect) begin
                // imem_req is low during a redirect, so no accept competes here.
                fetch_pc_q <= {redirect_pc[31:2], 2'b00};
                count_q    <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
                discard_q  <= inflight_q && !imem_rvalid;
            end else begin
                if (rsp && discard_q) begin
                    discard_q <= 1'b0;
                end
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                unique case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage needs no reset; entries are only read while count_q covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {imem_rdata, req_pc_q};
        end
    end

endmodule
